// File: rtl/seg7_pkg.sv
// Shared constants and the dwell-length helper for the 7-segment scan driver.
package seg7_pkg;
  localparam int NDIG_MAX = 8;
  localparam int DIGIT_W  = 4;
  localparam logic [NDIG_MAX-1:0] AN_ALL_OFF = 8'hFF;

  // Cycles each digit stays selected; never less than one.
  function automatic int scan_div(input int clk_hz, input int scan_hz, input int ndig);
    int d;
    d = clk_hz / (scan_hz * ndig);
    return (d < 1) ? 1 : d;
  endfunction
endpackage

// File: rtl/seg7_scan_driver_if.sv
// Write port and display outputs of the 7-segment scan driver.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic                        en;
  logic                        wr_en;
  logic [NDIG_MAX*DIGIT_W-1:0] wr_data;
  logic [NDIG_MAX-1:0]         wr_dp;
  logic                        upd_pending;
  logic [DIGIT_W-1:0]          code;
  logic [NDIG_MAX-1:0]         an;
  logic                        dp_n;

  modport master (
    output en, wr_en, wr_data, wr_dp,
    input  upd_pending, code, an, dp_n
  );

  modport slave (
    input  en, wr_en, wr_data, wr_dp,
    output upd_pending, code, an, dp_n
  );
endinterface

// File: rtl/seg7_scan_tick.sv
// Digit-dwell prescaler: tick pulses on the last cycle of each dwell period; holds while en=0.
module seg7_scan_tick
  import seg7_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1_000,
  parameter int NDIG    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int DIV   = scan_div(CLK_HZ, SCAN_HZ, NDIG);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver with double-buffered display value.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1_000,
  parameter int NDIG    = 8
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_driver_if.slave bus
);
  localparam int IDX_W = $clog2(NDIG_MAX);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  logic                        tick;
  logic [IDX_W-1:0]            idx;
  logic [NDIG_MAX*DIGIT_W-1:0] pend_data;
  logic [NDIG_MAX*DIGIT_W-1:0] act_data;
  logic [NDIG_MAX-1:0]         pend_dp;
  logic [NDIG_MAX-1:0]         act_dp;
  logic [NDIG_MAX-1:0]         lit;
  logic                        wr_d;
  logic                        commit;
  logic                        on;

  seg7_scan_tick #(
    .CLK_HZ  (CLK_HZ),
    .SCAN_HZ (SCAN_HZ),
    .NDIG    (NDIG)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .tick (tick)
  );

  // Running: swap only at the frame boundary so a frame never mixes two values.
  // Stopped: nothing is visible, so the write lands on the following cycle.
  assign commit = bus.en ? (tick && (idx == IDX_LAST)) : wr_d;

`ifdef SEG7_LZ_BLANK_EN
  function automatic logic [NDIG_MAX-1:0] lit_mask(input logic [NDIG_MAX*DIGIT_W-1:0] data);
    logic [NDIG_MAX-1:0] m;
    logic                seen;
    m    = '0;
    seen = 1'b0;
    for (int i = NDIG_MAX - 1; i >= 0; i--) begin
      if (i < NDIG) seen = seen | (data[i*DIGIT_W +: DIGIT_W] != '0);
      m[i] = seen || (i == 0);
    end
    return m;
  endfunction

  assign lit = lit_mask(act_data);
`else
  assign lit = '1;
`endif

  assign on = bus.en && lit[idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx             <= '0;
      wr_d            <= 1'b0;
      pend_data       <= '0;
      pend_dp         <= '0;
      act_data        <= '0;
      act_dp          <= '0;
      bus.upd_pending <= 1'b0;
    end else begin
      wr_d <= bus.wr_en;
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (commit) begin
        act_data        <= pend_data;
        act_dp          <= pend_dp;
        bus.upd_pending <= 1'b0;
      end
      // A write on the commit cycle stays pending; the commit took the older value.
      if (bus.wr_en) begin
        pend_data       <= bus.wr_data;
        pend_dp         <= bus.wr_dp;
        bus.upd_pending <= 1'b1;
      end
    end
  end

  // Output stage: registered view of the current idx and active buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.an   <= AN_ALL_OFF;
      bus.code <= '0;
      bus.dp_n <= 1'b1;
    end else begin
      bus.an   <= on ? ~(NDIG_MAX'(1) << idx) : AN_ALL_OFF;
      bus.code <= act_data[idx*DIGIT_W +: DIGIT_W];
      bus.dp_n <= ~(on && act_dp[idx]);
    end
  end
endmodule
